// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: segment bit order,
// blank code, hex decode table and a width helper.
package seg_pkg;

  // Segment code bit order is {g,f,e,d,c,b,a}. All segments are active-low.
  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG_BLANK = 7'h7F;

  // Entry n is the active-low pattern for hex digit n (lowercase b and d).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake between the appliance control logic and the scan controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic                    load;
  logic                    load_ack;

  modport master (
    output value_in,
    output dp_in,
    output digit_en,
    output lz_blank,
    output load,
    input  load_ack
  );

  modport slave (
    input  value_in,
    input  dp_in,
    input  digit_en,
    input  lz_blank,
    input  load,
    output load_ack
  );

endinterface

// File: rtl/seg_scan_ctrl_hex_seg_lut.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_seg_lut
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_code_t  seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode display scanner. A load lands in a pending
// buffer and is promoted to the active buffer only at a frame boundary,
// so a frame is always drawn from one consistent display word.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_ctrl_if.slave        bus,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int CW = clog2(SCAN_DIV);
  localparam int IW = clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          slot_end;
  logic          frame_end;

  logic [4*NUM_DIGITS-1:0] val_pend, val_act;
  logic [NUM_DIGITS-1:0]   dp_pend, dp_act;
  logic [NUM_DIGITS-1:0]   en_pend, en_act;
  logic                    lz_pend, lz_act;
  logic                    pend_valid;

  logic [3:0] cur_nibble;
  seg_code_t  cur_seg;
  logic       upper_zero;
  logic       in_blank;
  logic       digit_dark;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Slot prescaler and digit index; idx advances on the last cycle of a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Pending buffer: latest load wins; consumed (or bypassed) at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_pend   <= '0;
      dp_pend    <= '0;
      en_pend    <= '0;
      lz_pend    <= 1'b0;
      pend_valid <= 1'b0;
    end else if (bus.load && !frame_end) begin
      val_pend   <= bus.value_in;
      dp_pend    <= bus.dp_in;
      en_pend    <= bus.digit_en;
      lz_pend    <= bus.lz_blank;
      pend_valid <= 1'b1;
    end else if (frame_end) begin
      pend_valid <= 1'b0;
    end
  end

  // Active buffer only changes at the frame boundary; a coincident load bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_act <= '0;
      dp_act  <= '0;
      en_act  <= '0;
      lz_act  <= 1'b0;
    end else if (frame_end && bus.load) begin
      val_act <= bus.value_in;
      dp_act  <= bus.dp_in;
      en_act  <= bus.digit_en;
      lz_act  <= bus.lz_blank;
    end else if (frame_end && pend_valid) begin
      val_act <= val_pend;
      dp_act  <= dp_pend;
      en_act  <= en_pend;
      lz_act  <= lz_pend;
    end
  end

  // Frame and acknowledge pulses, both one cycle after the boundary cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick   <= 1'b0;
      bus.load_ack <= 1'b0;
    end else begin
      frame_tick   <= frame_end;
      bus.load_ack <= frame_end && (bus.load || pend_valid);
    end
  end

  assign cur_nibble = val_act[{idx, 2'b00} +: 4];

  hex_seg_lut u_lut (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Leading-zero test: every nibble from the current position upward is zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IW'(i) >= idx) && (val_act[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end
  end

  assign in_blank   = (cnt < BLANK_END);
  assign digit_dark = !en_act[idx] || (lz_act && (idx != '0) && upper_zero);

  // Registered pin drive; the guard interval and dark digits share the all-off pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (in_blank || digit_dark) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= cur_seg;
      dp  <= ~dp_act[idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short scan (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seg_scan_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int tests = 0;
  int fails = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advances to the negedge on which frame_tick is seen (at least one cycle).
  task automatic wait_frame();
    int k;
    k = 0;
    @(negedge clk);
    while (!frame_tick && k < 40) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (frame_tick !== 1'b1) begin
      fails++;
      $display("FAIL wait_frame: frame_tick=%b, required 1 within 40 cycles", frame_tick);
    end
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] e, input logic lz);
    bus.value_in = v;
    bus.dp_in    = d;
    bus.digit_en = e;
    bus.lz_blank = lz;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic test_reset();
    int ticks, first_tick, last_tick;
    bus.value_in = '0;
    bus.dp_in    = '0;
    bus.digit_en = '0;
    bus.lz_blank = 1'b0;
    bus.load     = 1'b0;
    rst_n        = 1'b0;
    #12;
    tests++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      fails++;
      $display("FAIL reset_pins: an=%b seg=%b dp=%b, required 1111 1111111 1", an, seg, dp);
    end
    tests++;
    if ({bus.load_ack, frame_tick} !== 2'b00) begin
      fails++;
      $display("FAIL reset_pulses: load_ack=%b frame_tick=%b, required 0 0", bus.load_ack, frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ticks = 0;
    first_tick = -1;
    last_tick = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      tests++;
      if ({an, seg, dp, bus.load_ack} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL idle_dark cycle %0d: an=%b seg=%b dp=%b ack=%b, required 1111 1111111 1 0",
                 i, an, seg, dp, bus.load_ack);
      end
      if (frame_tick) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
        last_tick = i;
      end
    end
    tests++;
    if (ticks !== 3) begin
      fails++;
      $display("FAIL idle_tick_count: got %0d, required 3", ticks);
    end
    tests++;
    if (first_tick !== 32 || last_tick !== 96) begin
      fails++;
      $display("FAIL idle_tick_spacing: first=%0d last=%0d, required 32 and 96", first_tick, last_tick);
    end
  endtask

  task automatic test_basic();
    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    drive_load(16'h1234, 4'h0, 4'hF, 1'b0);
    wait_frame();
    tests++;
    if (bus.load_ack !== 1'b1) begin
      fails++;
      $display("FAIL basic_ack: load_ack=%b, required 1", bus.load_ack);
    end
    for (int s = 0; s < 4; s++) begin
      step((s == 0) ? 2 : 7);
      tests++;
      if ({an, seg, dp, bus.load_ack} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL basic_guard slot %0d: an=%b seg=%b dp=%b ack=%b, required 1111 1111111 1 0",
                 s, an, seg, dp, bus.load_ack);
      end
      step(1);
      tests++;
      if ({an, seg, dp} !== {an_exp[s], seg_exp[s], 1'b1}) begin
        fails++;
        $display("FAIL basic_digit %0d: an=%b seg=%b dp=%b, required %b %b 1",
                 s, an, seg, dp, an_exp[s], seg_exp[s]);
      end
    end
  endtask

  task automatic test_lz_dp();
    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    logic       dp_exp [4];
    an_exp  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    seg_exp = '{7'b0100100, 7'b0011001, 7'h7F, 7'h7F};
    dp_exp  = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive_load(16'h0042, 4'b0010, 4'hF, 1'b1);
    wait_frame();
    tests++;
    if (bus.load_ack !== 1'b1) begin
      fails++;
      $display("FAIL lz_ack: load_ack=%b, required 1", bus.load_ack);
    end
    for (int s = 0; s < 4; s++) begin
      step((s == 0) ? 3 : 8);
      tests++;
      if ({an, seg, dp} !== {an_exp[s], seg_exp[s], dp_exp[s]}) begin
        fails++;
        $display("FAIL lz_digit %0d: an=%b seg=%b dp=%b, required %b %b %b",
                 s, an, seg, dp, an_exp[s], seg_exp[s], dp_exp[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks, saw_a, overlap;
    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{7'b0001110, 7'b0001110, 7'b1000000, 7'b1000000};
    wait_frame();
    step(2);
    drive_load(16'hAAAA, 4'h0, 4'hF, 1'b0);
    step(3);
    drive_load(16'h00FF, 4'h0, 4'hF, 1'b0);
    acks = 0;
    saw_a = 0;
    overlap = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.load_ack) acks++;
      if (seg == 7'b0001000) saw_a++;
      if ($countones(~an) > 1) overlap++;
    end
    tests++;
    if (acks !== 1) begin
      fails++;
      $display("FAIL b2b_ack_count: got %0d, required 1", acks);
    end
    tests++;
    if (saw_a !== 0) begin
      fails++;
      $display("FAIL b2b_stale_visible: A pattern seen %0d cycles, required 0", saw_a);
    end
    tests++;
    if (overlap !== 0) begin
      fails++;
      $display("FAIL anode_overlap: %0d cycles with >1 anode low, required 0", overlap);
    end
    wait_frame();
    tests++;
    if (bus.load_ack !== 1'b0) begin
      fails++;
      $display("FAIL b2b_no_second_ack: load_ack=%b, required 0", bus.load_ack);
    end
    for (int s = 0; s < 4; s++) begin
      step((s == 0) ? 3 : 8);
      tests++;
      if ({an, seg, dp} !== {an_exp[s], seg_exp[s], 1'b1}) begin
        fails++;
        $display("FAIL b2b_digit %0d: an=%b seg=%b dp=%b, required %b %b 1",
                 s, an, seg, dp, an_exp[s], seg_exp[s]);
      end
    end
  endtask

  task automatic test_bypass();
    wait_frame();
    step(31);
    tests++;
    if ({an, seg} !== {4'b0111, 7'b1000000}) begin
      fails++;
      $display("FAIL bypass_old_digit3: an=%b seg=%b, required 0111 1000000", an, seg);
    end
    bus.value_in = 16'h5678;
    bus.dp_in    = 4'h0;
    bus.digit_en = 4'hF;
    bus.lz_blank = 1'b0;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    tests++;
    if ({frame_tick, bus.load_ack} !== 2'b11) begin
      fails++;
      $display("FAIL bypass_ack_align: frame_tick=%b load_ack=%b, required 1 1", frame_tick, bus.load_ack);
    end
    tests++;
    if ({an, seg} !== {4'b0111, 7'b1000000}) begin
      fails++;
      $display("FAIL bypass_no_midframe: an=%b seg=%b, required 0111 1000000", an, seg);
    end
    step(3);
    tests++;
    if ({an, seg} !== {4'b1110, 7'b0000000}) begin
      fails++;
      $display("FAIL bypass_digit0: an=%b seg=%b, required 1110 0000000", an, seg);
    end
    step(8);
    tests++;
    if ({an, seg} !== {4'b1101, 7'b1111000}) begin
      fails++;
      $display("FAIL bypass_digit1: an=%b seg=%b, required 1101 1111000", an, seg);
    end
  endtask

  task automatic test_reset_mid();
    int dark_bad, acks, ticks;
    wait_frame();
    step(9);
    drive_load(16'h9999, 4'h0, 4'hF, 1'b0);
    step(1);
    tests++;
    if ({an, seg} !== {4'b1101, 7'b1111000}) begin
      fails++;
      $display("FAIL rstmid_before: an=%b seg=%b, required 1101 1111000", an, seg);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      fails++;
      $display("FAIL rstmid_async: an=%b seg=%b dp=%b, required 1111 1111111 1", an, seg, dp);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dark_bad = 0;
    acks = 0;
    ticks = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) dark_bad++;
      if (bus.load_ack) acks++;
      if (frame_tick) ticks++;
    end
    tests++;
    if (dark_bad !== 0) begin
      fails++;
      $display("FAIL rstmid_dark: %0d lit cycles after reset, required 0", dark_bad);
    end
    tests++;
    if (acks !== 0) begin
      fails++;
      $display("FAIL rstmid_pending_dropped: %0d acks, required 0", acks);
    end
    tests++;
    if (ticks !== 2) begin
      fails++;
      $display("FAIL rstmid_ticks: got %0d, required 2", ticks);
    end
    drive_load(16'h0001, 4'h0, 4'h1, 1'b0);
    wait_frame();
    tests++;
    if (bus.load_ack !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_reload_ack: load_ack=%b, required 1", bus.load_ack);
    end
    step(3);
    tests++;
    if ({an, seg} !== {4'b1110, 7'b1111001}) begin
      fails++;
      $display("FAIL rstmid_reload_digit0: an=%b seg=%b, required 1110 1111001", an, seg);
    end
    step(8);
    tests++;
    if (an !== 4'b1111) begin
      fails++;
      $display("FAIL disabled_digit1: an=%b, required 1111", an);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz_dp();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
